// File: rtl/ram_arbiter_2p_pkg.sv
// Shared definitions for the two-port RAM arbiter: FSM encoding, default
// geometry and the round-robin winner selection.
package ram_arbiter_2p_pkg;

  localparam int AW_DEF = 3;
  localparam int DW_DEF = 8;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GRANT = 2'd1,
    S_RESP  = 2'd2
  } state_e;

  // Lone requester wins; on contention the port named by rr_ptr wins.
  function automatic logic arb_pick(input logic req0, input logic req1, input logic rr_ptr);
    if (req0 && req1) begin
      return rr_ptr;
    end else begin
      return req1;
    end
  endfunction

endpackage

// File: rtl/ram_arbiter_2p_if.sv
// Request/grant/response bundle between the two requesters and the arbiter.
interface ram_arbiter_2p_if #(
  parameter int AW = ram_arbiter_2p_pkg::AW_DEF,
  parameter int DW = ram_arbiter_2p_pkg::DW_DEF
) ();

  logic          req0;
  logic          req1;
  logic          we0;
  logic          we1;
  logic [AW-1:0] addr0;
  logic [AW-1:0] addr1;
  logic [DW-1:0] wdata0;
  logic [DW-1:0] wdata1;
  logic          gnt0;
  logic          gnt1;
  logic          rvalid0;
  logic          rvalid1;
  logic [DW-1:0] rdata;
  logic          busy;

  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
    input  gnt0, gnt1, rvalid0, rvalid1, rdata, busy
  );

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
    output gnt0, gnt1, rvalid0, rvalid1, rdata, busy
  );

endinterface

// File: rtl/ram_arbiter_2p_ram_sp_sync.sv
// Single-port synchronous RAM: posedge write, registered read. The array is
// deliberately not reset; only the read register is.
module ram_arbiter_2p_ram_sp_sync #(
  parameter int AW = ram_arbiter_2p_pkg::AW_DEF,
  parameter int DW = ram_arbiter_2p_pkg::DW_DEF
) (
  input  logic          clk,
  input  logic          clrn,
  input  logic          en_i,
  input  logic          we_i,
  input  logic [AW-1:0] addr_i,
  input  logic [DW-1:0] wdata_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem_q [2**AW];
  logic [DW-1:0] rdata_q;

  // Array write port
  always_ff @(posedge clk) begin
    if (en_i && we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

  // Read register holds its value between reads
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      rdata_q <= {DW{1'b0}};
    end else if (en_i && !we_i) begin
      rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/ram_arbiter_2p.sv
// Round-robin arbiter sharing one single-port RAM between two requesters;
// one access in flight, registered grant and read-valid pulses.
module ram_arbiter_2p
  import ram_arbiter_2p_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
) (
  input  logic             clk,
  input  logic             clrn,
  ram_arbiter_2p_if.slave  bus
);

  state_e        state_q, state_d;
  logic          win_q, win_d;
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic          rr_q, rr_d;
  logic          gnt0_q, gnt0_d;
  logic          gnt1_q, gnt1_d;
  logic          rvalid0_q, rvalid0_d;
  logic          rvalid1_q, rvalid1_d;
  logic          busy_q, busy_d;
  logic          accept_s;
  logic          pick_s;
  logic          ram_en_s;
  logic [DW-1:0] ram_rdata_s;

  // State register
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; requests are only looked at in IDLE
  always_comb begin
    state_d  = S_IDLE;
    accept_s = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.req0 || bus.req1) begin
          state_d  = S_GRANT;
          accept_s = 1'b1;
        end else begin
          state_d  = S_IDLE;
        end
      end
      S_GRANT: begin
        if (we_q) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_RESP;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Request latch and round-robin pointer update on acceptance
  always_comb begin
    pick_s = arb_pick(bus.req0, bus.req1, rr_q);
    if (accept_s) begin
      win_d   = pick_s;
      we_d    = pick_s ? bus.we1    : bus.we0;
      addr_d  = pick_s ? bus.addr1  : bus.addr0;
      wdata_d = pick_s ? bus.wdata1 : bus.wdata0;
      rr_d    = ~pick_s;
    end else begin
      win_d   = win_q;
      we_d    = we_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      rr_d    = rr_q;
    end
  end

  // Output decode from the upcoming state so the pulses come out of flops
  always_comb begin
    gnt0_d    = (state_d == S_GRANT) && !win_d;
    gnt1_d    = (state_d == S_GRANT) &&  win_d;
    rvalid0_d = (state_d == S_RESP)  && !win_d;
    rvalid1_d = (state_d == S_RESP)  &&  win_d;
    busy_d    = (state_d != S_IDLE);
  end

  // Datapath and output registers
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      win_q     <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= {AW{1'b0}};
      wdata_q   <= {DW{1'b0}};
      rr_q      <= 1'b0;
      gnt0_q    <= 1'b0;
      gnt1_q    <= 1'b0;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      win_q     <= win_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rr_q      <= rr_d;
      gnt0_q    <= gnt0_d;
      gnt1_q    <= gnt1_d;
      rvalid0_q <= rvalid0_d;
      rvalid1_q <= rvalid1_d;
      busy_q    <= busy_d;
    end
  end

  // The RAM operation completes at the edge that closes the GRANT cycle
  assign ram_en_s = (state_q == S_GRANT);

  ram_arbiter_2p_ram_sp_sync #(.AW(AW), .DW(DW)) u_ram (
    .clk     (clk),
    .clrn    (clrn),
    .en_i    (ram_en_s),
    .we_i    (we_q),
    .addr_i  (addr_q),
    .wdata_i (wdata_q),
    .rdata_o (ram_rdata_s)
  );

  assign bus.gnt0    = gnt0_q;
  assign bus.gnt1    = gnt1_q;
  assign bus.rvalid0 = rvalid0_q;
  assign bus.rvalid1 = rvalid1_q;
  assign bus.rdata   = ram_rdata_s;
  assign bus.busy    = busy_q;

endmodule
